// File: rtl/bsg_manycore_host_req_arbiter.sv
// Round-robin arbiter sharing one host manycore request/response FIFO pair among num_req_p requesters.
// Optional BSG_MANYCORE_HOST_ARB_DROP_UNEXPECTED_EN: consume unexpected responses and raise sticky err_o.
module bsg_manycore_host_req_arbiter #(
    parameter int unsigned num_req_p      = 2,
    parameter int unsigned fifo_width_p   = 128,
    parameter int unsigned op_offset_p    = 0,
    parameter int unsigned read_credits_p = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p*fifo_width_p-1:0]   req_i,
    input  logic [num_req_p-1:0]                req_v_i,
    output logic [num_req_p-1:0]                req_ready_o,
    output logic [fifo_width_p-1:0]             rsp_o,
    output logic [num_req_p-1:0]                rsp_v_o,
    input  logic [num_req_p-1:0]                rsp_ready_i,
    output logic [fifo_width_p-1:0]             fifo_req_o,
    output logic                                fifo_req_v_o,
    input  logic                                fifo_req_ready_i,
    input  logic [fifo_width_p-1:0]             fifo_rsp_i,
    input  logic                                fifo_rsp_v_i,
    output logic                                fifo_rsp_ready_o,
    output logic [$clog2(read_credits_p+1)-1:0] outstanding_o,
    output logic                                err_o
);

    localparam int unsigned idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned cnt_w = $clog2(read_credits_p + 1);
    localparam int unsigned ptr_w = (read_credits_p > 1) ? $clog2(read_credits_p) : 1;
    localparam logic [7:0]  e_remote_load = 8'h00;

    typedef enum logic {e_idle, e_lock} state_e;

    state_e                 state_r, state_n;
    logic [idx_w-1:0]       rr_ptr_r, lock_idx_r, rr_idx, grant_idx, head;
    logic [idx_w:0]         cand;
    logic                   rr_found, grant_v, req_hs, credit_avail;
    logic                   push, pop, empty;
    logic [num_req_p-1:0]   is_load, eligible;
    logic [ptr_w-1:0]       wr_ptr_r, rd_ptr_r;
    logic [idx_w-1:0]       order_mem_r [read_credits_p];

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(read_credits_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign credit_avail = (outstanding_o < cnt_w'(read_credits_p));

    // Loads need a free read credit to be eligible; everything else only needs valid.
    always_comb begin
        is_load  = '0;
        eligible = '0;
        for (int k = 0; k < int'(num_req_p); k++) begin
            is_load[k]  = (req_i[k*fifo_width_p + op_offset_p +: 8] == e_remote_load);
            eligible[k] = req_v_i[k] & (~is_load[k] | credit_avail);
        end
    end

    // First eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_ptr_r;
        cand     = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            cand = (idx_w+1)'(rr_ptr_r) + (idx_w+1)'(i);
            if (cand >= (idx_w+1)'(num_req_p)) begin
                cand = cand - (idx_w+1)'(num_req_p);
            end
            if (!rr_found && eligible[cand[idx_w-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[idx_w-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle:  if (fifo_req_v_o && !fifo_req_ready_i) state_n = e_lock;
            e_lock:  if (req_hs) state_n = e_idle;
            default: state_n = e_idle;
        endcase
    end

    // LOCK pins the grant so fifo_req_o stays stable until the handshake.
    always_comb begin
        grant_idx  = rr_idx;
        grant_v    = rr_found;
        fifo_req_o = '0;
        if (state_r == e_lock) begin
            grant_idx = lock_idx_r;
            grant_v   = eligible[lock_idx_r];
        end
        for (int k = 0; k < int'(num_req_p); k++) begin
            if (grant_idx == idx_w'(k)) fifo_req_o = req_i[k*fifo_width_p +: fifo_width_p];
        end
        fifo_req_v_o = reset_n_i & grant_v;
        req_hs       = fifo_req_v_o & fifo_req_ready_i;
        req_ready_o  = req_hs ? (num_req_p'(1) << grant_idx) : '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_r   <= '0;
            lock_idx_r <= '0;
        end else begin
            if (req_hs) begin
                rr_ptr_r <= (grant_idx == idx_w'(num_req_p - 1)) ? '0 : grant_idx + idx_w'(1);
            end
            if (state_r == e_idle && state_n == e_lock) lock_idx_r <= grant_idx;
        end
    end

    assign push  = req_hs & is_load[grant_idx];
    assign empty = (outstanding_o == '0);
    assign head  = order_mem_r[rd_ptr_r];
    assign pop   = fifo_rsp_v_i & fifo_rsp_ready_o & ~empty;

    always_ff @(posedge clk_i) begin
        if (push) order_mem_r[wr_ptr_r] <= grant_idx;
    end

    // Occupancy of the order FIFO doubles as the outstanding-load count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            outstanding_o <= '0;
        end else begin
            if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            if (push && !pop) begin
                outstanding_o <= outstanding_o + cnt_w'(1);
            end else if (pop && !push) begin
                outstanding_o <= outstanding_o - cnt_w'(1);
            end
        end
    end

    // Steer in-order responses back to the requester at the order-FIFO head.
    always_comb begin
        rsp_o            = fifo_rsp_i;
        rsp_v_o          = '0;
        fifo_rsp_ready_o = 1'b0;
        if (reset_n_i) begin
            if (!empty) begin
                rsp_v_o          = fifo_rsp_v_i ? (num_req_p'(1) << head) : '0;
                fifo_rsp_ready_o = rsp_ready_i[head];
            end
`ifdef BSG_MANYCORE_HOST_ARB_DROP_UNEXPECTED_EN
            else begin
                fifo_rsp_ready_o = 1'b1;
            end
`endif
        end
    end

`ifdef BSG_MANYCORE_HOST_ARB_DROP_UNEXPECTED_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o <= 1'b0;
        end else if (fifo_rsp_v_i && fifo_rsp_ready_o && empty) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
